i2c_burst_sequencer: RTL

- Command sequencer directly upstream of the I2C byte controller.
- After i_go, writes a fixed register-init table to one sensor, then serves read requests on i_trig.
- Drives the controller's dev-addr, reg-addr, write-data and control inputs, and watches its ready status bit.
- Returns each read byte to the host with a one-cycle valid strobe; flags timeouts.

---
 rtl/i2c_burst_sequencer_pkg.sv | 48 ++++
 rtl/i2c_burst_sequencer_init_rom.sv | 14 +
 rtl/i2c_burst_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/i2c_burst_sequencer_pkg.sv
// i2c_seq_pkg: state encoding, control-word layout, op modes and init table for the I2C burst sequencer
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        NEXT,
        RUN
    } state_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RW      = 1;
    localparam int CTRL_MODE_LO = 2;
    localparam int CTRL_MODE_HI = 3;

    localparam logic [1:0] MODE_CPU1   = 2'b00;
    localparam logic [1:0] MODE_CPU11  = 2'b01;
    localparam logic [1:0] MODE_FPGA11 = 2'b10;

    localparam int IDX_W = 4;
    localparam int TMO_W = 16;

    // {reg, data} pairs written to the sensor after i_go; only the first INIT_LEN are used
    function automatic logic [15:0] init_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 16'h0070;
            4'd1:    return 16'h01A0;
            4'd2:    return 16'h0200;
            4'd3:    return 16'h2040;
            4'd4:    return 16'h2160;
            4'd5:    return 16'h2208;
            4'd6:    return 16'h2300;
            4'd7:    return 16'h2480;
            4'd8:    return 16'h3010;
            4'd9:    return 16'h3122;
            4'd10:   return 16'h3233;
            4'd11:   return 16'h3344;
            4'd12:   return 16'h3455;
            4'd13:   return 16'h3566;
            4'd14:   return 16'h3677;
            default: return 16'h3788;
        endcase
    endfunction

endpackage

// File: rtl/i2c_burst_sequencer_init_rom.sv
// i2c_init_rom: combinational lookup of the sensor init table, zero beyond INIT_LEN
module i2c_init_rom
    import i2c_seq_pkg::*;
#(
    parameter int INIT_LEN = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      entry
);

    // entries past the configured length read as zero so a stray index never writes junk
    always_comb entry = (int'(idx) < INIT_LEN) ? init_entry(idx) : '0;

endmodule

// File: rtl/i2c_burst_sequencer.sv
// i2c_burst_sequencer: writes the init table to one sensor, then issues single-register reads on request
module i2c_burst_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1E,
    parameter int         INIT_LEN = 4,
    parameter int         TIMEOUT  = 20000,
    parameter logic [1:0] RD_MODE  = MODE_CPU1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic        i_trig,
    input  logic [7:0]  i_rd_addr,
    input  logic        i_ready,
    input  logic [7:0]  i_rd_data,
    output logic [6:0]  o_dev_addr,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_w_data,
    output logic [31:0] o_ctrl,
    output logic [7:0]  o_data,
    output logic        o_data_vld,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       rom_entry;
    logic              rdy_m, rdy_s, rdy_s_d;
    logic [1:0]        edge_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              en, rw;
    logic [1:0]        mode;
    logic              rise, waiting, tmo_hit, done_ev, adv, abort, last_idx, restart, accept;

    i2c_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
        .idx   (idx),
        .entry (rom_entry)
    );

    // event decode shared by the next-state logic and the datapath
    always_comb begin
        rise     = rdy_s & ~rdy_s_d;
        waiting  = state inside {ISSUE, WAIT_BUSY, WAIT_DONE};
        tmo_hit  = waiting && tmo_cnt == TMO_MAX;
        done_ev  = state == WAIT_DONE && rise && (!rw || edge_cnt == 2'd1);
        adv      = (state == ISSUE && rdy_s) || (state == WAIT_BUSY && !rdy_s) || done_ev;
        abort    = tmo_hit && !adv;
        last_idx = idx == LAST_IDX;
        restart  = i_go && (state == IDLE || state == RUN);
        accept   = state == RUN && i_trig && !i_go;
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state; a timeout overrides any wait, falling back to RUN for reads and IDLE for init
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = i_go ? LOAD : IDLE;
            LOAD:      state_nxt = ISSUE;
            ISSUE:     state_nxt = rdy_s ? WAIT_BUSY : ISSUE;
            WAIT_BUSY: state_nxt = !rdy_s ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_nxt = done_ev ? NEXT : WAIT_DONE;
            NEXT:      state_nxt = (rw || last_idx) ? RUN : LOAD;
            RUN:       state_nxt = i_go ? LOAD : (i_trig ? ISSUE : RUN);
            default:   state_nxt = IDLE;
        endcase
        if (abort) state_nxt = rw ? RUN : IDLE;
    end

    // datapath: ready synchroniser, wait timers, transaction fields and host-facing results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_m       <= 1'b0;
            rdy_s       <= 1'b0;
            rdy_s_d     <= 1'b0;
            tmo_cnt     <= '0;
            edge_cnt    <= '0;
            idx         <= '0;
            o_reg_addr  <= '0;
            o_w_data    <= '0;
            rw          <= 1'b0;
            mode        <= '0;
            en          <= 1'b0;
            o_init_done <= 1'b0;
            o_data      <= '0;
            o_data_vld  <= 1'b0;
            o_err       <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            rdy_m      <= i_ready;
            rdy_s      <= rdy_m;
            rdy_s_d    <= rdy_s;
            tmo_cnt    <= (state_nxt != state || !waiting) ? '0 : tmo_cnt + 1'b1;
            edge_cnt   <= (state != WAIT_DONE) ? '0 : edge_cnt + {1'b0, rise && edge_cnt != 2'd2};
            if (restart)
                idx <= '0;
            else if (state == NEXT && !rw && !last_idx)
                idx <= idx + 1'b1;
            if (state == LOAD) begin
                o_reg_addr <= rom_entry[15:8];
                o_w_data   <= rom_entry[7:0];
                rw         <= 1'b0;
                mode       <= MODE_CPU1;
            end else if (accept) begin
                o_reg_addr <= i_rd_addr;
                rw         <= 1'b1;
                mode       <= RD_MODE;
            end
            en          <= (en || (state == ISSUE && rdy_s)) && !(state == WAIT_BUSY && !rdy_s) && !abort;
            o_init_done <= (state == NEXT && !rw && last_idx) || (o_init_done && !restart && !(abort && !rw));
            o_data_vld  <= state == NEXT && rw;
            if (state == NEXT && rw)
                o_data <= i_rd_data;
            o_err <= abort;
            if (abort && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    // outputs decoded from state and the transaction fields
    always_comb begin
        o_dev_addr                        = DEV_ADDR;
        o_busy                            = !(state inside {IDLE, RUN});
        o_ctrl                            = '0;
        o_ctrl[CTRL_EN]                   = en;
        o_ctrl[CTRL_RW]                   = rw;
        o_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
    end

endmodule
